// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: merges ID/MEM stall requests, sequences
// multi-cycle EX ops through IDLE/BUSY/DONE, and counts PC-stall cycles.
module pipe_stall_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_mem,
   input  logic             mc_start,
   input  logic             mc_cancel,
   input  logic             perf_clr,
   output logic [5:0]       stall,
   output logic             mc_busy,
   output logic             mc_done,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int CW = $clog2(MC_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          ex_req;

   // The entry cycle in IDLE already stalls EX, so BUSY only covers the rest.
   always_comb ex_req = ~mc_cancel & (((state == IDLE) & mc_start) | (state == BUSY));

   // Gated by reset so the outputs hold their reset values while rst is low.
   always_comb begin
      stall = 6'b000000;
      if (!rst)              stall = 6'b000000;
      else if (stallreq_mem) stall = 6'b011111;
      else if (ex_req)       stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
   end

   assign mc_busy = (state == BUSY);
   assign mc_done = (state == DONE) & ~mc_cancel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (mc_cancel) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (mc_start) begin
               state <= BUSY;
               cnt   <= CW'(MC_CYCLES - 1);
            end
            BUSY: if (cnt == CW'(1)) state <= DONE;
                  else               cnt   <= cnt - CW'(1);
            // The finishing op still presents mc_start here, so it is ignored.
            DONE: if (!stallreq_mem) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                            stall_cnt <= '0;
      else if (perf_clr)                   stall_cnt <= '0;
      else if (stall[0] && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       stallreq_id, stallreq_mem, mc_start, mc_cancel, perf_clr;
   logic [5:0] stall;
   logic       mc_busy, mc_done;
   logic [3:0] stall_cnt;

   pipe_stall_ctrl #(.MC_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
      .mc_start(mc_start), .mc_cancel(mc_cancel), .perf_clr(perf_clr),
      .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [5:0] stall;
      logic       busy;
      logic       done;
      logic [3:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   nvec = 0;
   int   nerr = 0;
   int   vid  = 0;

   // Inputs for one cycle plus the outputs expected during that cycle
   // (stall_cnt is the value before this cycle's edge updates it).
   task automatic vec(input logic id, mem, start, cancel, clr,
                      input logic [5:0] s, input logic b, d, input logic [3:0] c);
      exp_t x;
      @(posedge clk); #1;
      stallreq_id = id; stallreq_mem = mem; mc_start = start;
      mc_cancel = cancel; perf_clr = clr;
      x.idx = vid; x.stall = s; x.busy = b; x.done = d; x.cnt = c;
      vid++;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         nvec++;
         if (stall !== e.stall || mc_busy !== e.busy || mc_done !== e.done || stall_cnt !== e.cnt) begin
            nerr++;
            $display("FAIL vec%0d: got stall=%b busy=%b done=%b cnt=%0d, want stall=%b busy=%b done=%b cnt=%0d",
                     e.idx, stall, mc_busy, mc_done, stall_cnt, e.stall, e.busy, e.done, e.cnt);
         end
      end
   end

   initial begin
      rst = 1'b0;
      stallreq_id = 0; stallreq_mem = 0; mc_start = 0; mc_cancel = 0; perf_clr = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // reset state
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd0);
      // load-use single cycle
      vec(1,0,0,0,0, 6'b000111, 0,0, 4'd0);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd1);
      vec(0,0,0,0,1, 6'b000000, 0,0, 4'd1);
      // multi-cycle op, mc_start held, 4 stall cycles then done
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd0);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd1);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd2);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd3);
      vec(0,0,1,0,0, 6'b000000, 0,1, 4'd4);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd4);
      vec(0,0,0,0,1, 6'b000000, 0,0, 4'd4);
      // MEM stall over the tail of the op; done held until MEM clears
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd0);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd1);
      vec(0,1,1,0,0, 6'b011111, 1,0, 4'd2);
      vec(0,1,1,0,0, 6'b011111, 1,0, 4'd3);
      vec(0,1,1,0,0, 6'b011111, 0,1, 4'd4);
      vec(0,1,1,0,0, 6'b011111, 0,1, 4'd5);
      vec(0,0,0,0,0, 6'b000000, 0,1, 4'd6);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd6);
      vec(0,0,0,0,1, 6'b000000, 0,0, 4'd6);
      // cancel in the second BUSY cycle: no done pulse
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd0);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd1);
      vec(0,0,1,1,0, 6'b000000, 1,0, 4'd2);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd2);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd2);
      vec(0,0,0,0,1, 6'b000000, 0,0, 4'd2);
      // back-to-back ops: one unstalled done cycle, then restart; cancel the second
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd0);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd1);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd2);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd3);
      vec(0,0,1,0,0, 6'b000000, 0,1, 4'd4);
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd4);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd5);
      vec(0,0,1,1,0, 6'b000000, 1,0, 4'd6);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd6);
      vec(0,0,0,0,1, 6'b000000, 0,0, 4'd6);
      // counter saturation with a 4-bit counter
      for (int k = 0; k < 20; k++)
         vec(1,0,0,0,0, 6'b000111, 0,0, (k > 15) ? 4'd15 : 4'(k));
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd15);
      // clear wins over a concurrent increment
      vec(1,0,0,0,1, 6'b000111, 0,0, 4'd15);
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd0);
      // async reset mid-BUSY
      vec(0,0,1,0,0, 6'b001111, 0,0, 4'd0);
      vec(0,0,1,0,0, 6'b001111, 1,0, 4'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      nvec++;
      if (stall !== 6'b0 || mc_busy !== 1'b0 || mc_done !== 1'b0 || stall_cnt !== 4'd0) begin
         nerr++;
         $display("FAIL async_reset: got stall=%b busy=%b done=%b cnt=%0d, want all zero",
                  stall, mc_busy, mc_done, stall_cnt);
      end
      mc_start = 0;
      @(negedge clk);
      rst = 1'b1;
      vec(0,0,0,0,0, 6'b000000, 0,0, 4'd0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
